// File: rtl/button_conditioner.sv
// button_conditioner: synchronizes, debounces and edge-detects the raw mode/up/down
// buttons into single-cycle pulses. When BUTTON_AUTOREPEAT_EN is defined, a held
// up/down button also auto-repeats. Holding up and down together suppresses both.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned REPEAT_DELAY    = 10,
    parameter int unsigned REPEAT_RATE     = 3,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic CLK,
    input  logic reset,
    input  logic mode_raw,
    input  logic up_raw,
    input  logic down_raw,
    output logic mode_pulse,
    output logic up_pulse,
    output logic down_pulse,
    output logic any_held
);

    localparam int unsigned NB  = 3;
    localparam int unsigned DBW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [NB-1:0] RELEASED_RAW = {NB{ACTIVE_LOW}};

    // Bit 0 = mode, bit 1 = up, bit 2 = down
    logic [NB-1:0]  raw_bus;
    logic [NB-1:0]  sync1;
    logic [NB-1:0]  sync2;
    logic [NB-1:0]  pressed;
    logic [NB-1:0]  db;
    logic [NB-1:0]  db_q;
    logic [NB-1:0]  rise;
    logic [DBW-1:0] db_cnt [NB];

    assign raw_bus = {down_raw, up_raw, mode_raw};
    assign pressed = ACTIVE_LOW ? ~sync2 : sync2;
    assign rise    = db & ~db_q;

    // Out-of-range parameters leave this block unelaborated-safe; only a marker lives here
    if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_param_guard
        localparam int unsigned PARAM_OUT_OF_RANGE = 1;
    end

    // Two-flop synchronizer, cleared to the released raw level
    always_ff @(posedge CLK) begin
        if (reset) begin
            sync1 <= RELEASED_RAW;
            sync2 <= RELEASED_RAW;
        end else begin
            sync1 <= raw_bus;
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < NB; i++) begin : g_debounce
        // Accept a new level only after DEBOUNCE_CYCLES consecutive disagreeing samples
        always_ff @(posedge CLK) begin
            if (reset) begin
                db_cnt[i] <= '0;
                db[i]     <= 1'b0;
            end else if (pressed[i] == db[i]) begin
                db_cnt[i] <= '0;
            end else if (db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt[i] <= '0;
                db[i]     <= ~db[i];
            end else begin
                db_cnt[i] <= db_cnt[i] + DBW'(1);
            end
        end
    end

    // Edge-detect history, mode press pulse and held indicator
    always_ff @(posedge CLK) begin
        if (reset) begin
            db_q       <= '0;
            mode_pulse <= 1'b0;
            any_held   <= 1'b0;
        end else begin
            db_q       <= db;
            mode_pulse <= rise[0];
            any_held   <= |db;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCW     = $clog2(RPT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DELAY  = 2'd1,
        ST_REPEAT = 2'd2,
        ST_LOCK   = 2'd3
    } state_t;

    state_t         state;
    logic [RCW-1:0] rpt_cnt;
    logic           dir_down;
    logic           held_level;

    assign held_level = dir_down ? db[2] : db[1];

    // Shared up/down press + auto-repeat FSM; both held forces LOCK
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            rpt_cnt    <= '0;
            dir_down   <= 1'b0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            if (db[1] && db[2]) begin
                state <= ST_LOCK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise[1]) begin
                            up_pulse <= 1'b1;
                            dir_down <= 1'b0;
                            rpt_cnt  <= RCW'(REPEAT_DELAY - 1);
                            state    <= ST_DELAY;
                        end else if (rise[2]) begin
                            down_pulse <= 1'b1;
                            dir_down   <= 1'b1;
                            rpt_cnt    <= RCW'(REPEAT_DELAY - 1);
                            state      <= ST_DELAY;
                        end
                    end
                    ST_DELAY, ST_REPEAT: begin
                        if (!held_level) begin
                            state <= ST_IDLE;
                        end else if (rpt_cnt == '0) begin
                            up_pulse   <= ~dir_down;
                            down_pulse <= dir_down;
                            rpt_cnt    <= RCW'(REPEAT_RATE - 1);
                            state      <= ST_REPEAT;
                        end else begin
                            rpt_cnt <= rpt_cnt - RCW'(1);
                        end
                    end
                    ST_LOCK: begin
                        if (!db[1] && !db[2]) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOCK = 2'd1
    } state_t;

    state_t state;

    // One pulse per up/down press; both held forces LOCK
    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= ST_IDLE;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            if (db[1] && db[2]) begin
                state <= ST_LOCK;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (rise[1])      up_pulse   <= 1'b1;
                        else if (rise[2]) down_pulse <= 1'b1;
                    end
                    ST_LOCK: begin
                        if (!db[1] && !db[2]) state <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity, each
// cycle compared against a behavioural model (stable-run debounce, absolute-time repeat).
module tb_button_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic mode_raw = 1'b1;
    logic up_raw = 1'b1;
    logic down_raw = 1'b1;
    logic mode_pulse, up_pulse, down_pulse, any_held;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK), .reset(reset),
        .mode_raw(mode_raw), .up_raw(up_raw), .down_raw(down_raw),
        .mode_pulse(mode_pulse), .up_pulse(up_pulse), .down_pulse(down_pulse),
        .any_held(any_held)
    );

    always #5 CLK = ~CLK;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    // Model state, all in the "pressed = 1" domain; index 0 mode, 1 up, 2 down
    bit m_s1 [3];
    bit m_s2 [3];
    bit m_db [3];
    bit m_dbq [3];
    int m_run [3];
    int m_st = 0;       // 0 idle, 1 waiting first repeat, 2 repeating, 3 locked
    int m_dir = 1;      // 1 up, 2 down
    int m_fire = 0;     // absolute cycle of next repeat pulse
    bit e_mode, e_up, e_down, e_any;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit [2:0] prs);
        bit ur, dr, up, dn;
        if (r) begin
            for (int i = 0; i < 3; i++) begin
                m_s1[i] = 0; m_s2[i] = 0; m_db[i] = 0; m_dbq[i] = 0; m_run[i] = 0;
            end
            m_st = 0; m_dir = 1;
            e_mode = 0; e_up = 0; e_down = 0; e_any = 0;
            return;
        end
        up = m_db[1]; dn = m_db[2];
        ur = m_db[1] && !m_dbq[1];
        dr = m_db[2] && !m_dbq[2];
        e_mode = m_db[0] && !m_dbq[0];
        e_any  = m_db[0] || m_db[1] || m_db[2];
        e_up = 0; e_down = 0;
        if (up && dn) begin
            m_st = 3;
        end else if (m_st == 0) begin
            if (ur || dr) begin
                m_dir = ur ? 1 : 2;
                if (ur) e_up = 1; else e_down = 1;
`ifdef BUTTON_AUTOREPEAT_EN
                m_st = 1;
                m_fire = cyc + RD;
`endif
            end
        end else if (m_st == 3) begin
            if (!up && !dn) m_st = 0;
        end else begin
            if (!m_db[m_dir]) begin
                m_st = 0;
            end else if (cyc == m_fire) begin
                if (m_dir == 1) e_up = 1; else e_down = 1;
                m_fire = cyc + RR;
                m_st = 2;
            end
        end
        for (int i = 0; i < 3; i++) begin
            m_dbq[i] = m_db[i];
            if (m_s2[i] == m_db[i]) begin
                m_run[i] = 0;
            end else begin
                m_run[i]++;
                if (m_run[i] == D) begin
                    m_db[i] = !m_db[i];
                    m_run[i] = 0;
                end
            end
            m_s2[i] = m_s1[i];
            m_s1[i] = prs[i];
        end
    endtask

    // One clock: drive on negedge, advance model at posedge, compare shortly after
    task automatic step(input bit r, input bit [2:0] prs);
        @(negedge CLK);
        reset    = r;
        mode_raw = !prs[0];
        up_raw   = !prs[1];
        down_raw = !prs[2];
        @(posedge CLK);
        cyc++;
        model_step(r, prs);
        #1;
        chk("mode_pulse", 32'(mode_pulse), 32'(e_mode));
        chk("up_pulse",   32'(up_pulse),   32'(e_up));
        chk("down_pulse", 32'(down_pulse), 32'(e_down));
        chk("any_held",   32'(any_held),   32'(e_any));
        chk("up_down_excl", 32'(up_pulse & down_pulse), 32'd0);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 3'b000);
    endtask

    initial begin
        int first, cnt, seen, drop;
        int upq [$];
        bit [2:0] prs;
        int rem [3];

        // Reset state
        for (int k = 0; k < 3; k++) step(1'b1, 3'b000);
        idle(5);

        // 1: up held 20 cycles -> pulse latency and repeat spacing
        upq.delete();
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 3'b010);
            if (up_pulse) upq.push_back(k);
        end
        first = -1;
        for (int k = 0; k < 12; k++) begin
            step(1'b0, 3'b000);
            if (!any_held && first < 0) first = k;
        end
        chk("t1_first_pulse", 32'(upq.size() > 0 ? upq[0] : -1), 32'd6);
`ifdef BUTTON_AUTOREPEAT_EN
        chk("t1_count", 32'(upq.size()), 32'd3);
        chk("t1_delay_pulse", 32'(upq.size() > 1 ? upq[1] : -1), 32'd16);
        chk("t1_rate_pulse", 32'(upq.size() > 2 ? upq[2] : -1), 32'd19);
`else
        chk("t1_count", 32'(upq.size()), 32'd1);
`endif
        chk("t1_any_drop", 32'(first), 32'd6);
        idle(5);

        // 2: mode glitches of 3 cycles are rejected
        seen = 0;
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 3; k++) begin step(1'b0, 3'b001); seen += int'(mode_pulse | any_held); end
            for (int k = 0; k < 6; k++) begin step(1'b0, 3'b000); seen += int'(mode_pulse | any_held); end
        end
        chk("t2_glitch", 32'(seen), 32'd0);

        // 3: mode held 40 cycles -> one pulse at 6, none on release
        first = -1; cnt = 0;
        for (int k = 0; k < 40; k++) begin
            step(1'b0, 3'b001);
            if (mode_pulse) begin cnt++; if (first < 0) first = k; end
        end
        chk("t3_latency", 32'(first), 32'd6);
        for (int k = 0; k < 15; k++) begin step(1'b0, 3'b000); if (mode_pulse) cnt++; end
        chk("t3_count", 32'(cnt), 32'd1);

        // 4: up held, down joins 8 cycles later -> lock
        cnt = 0;
        for (int k = 0; k < 8; k++) begin step(1'b0, 3'b010); cnt += int'(up_pulse | down_pulse); end
        for (int k = 0; k < 25; k++) begin step(1'b0, 3'b110); cnt += int'(up_pulse | down_pulse); end
        chk("t4_lock_pulses", 32'(cnt), 32'd1);
        idle(15);
        first = -1;
        for (int k = 0; k < 10; k++) begin step(1'b0, 3'b010); if (up_pulse && first < 0) first = k; end
        chk("t4_repress", 32'(first), 32'd6);
        idle(15);

        // 5: reset during hold discards progress; held button re-pulses after debounce
        for (int k = 0; k < 9; k++) step(1'b0, 3'b010);
        for (int k = 0; k < 2; k++) step(1'b1, 3'b010);
        first = -1;
        for (int k = 0; k < 12; k++) begin step(1'b0, 3'b010); if (up_pulse && first < 0) first = k; end
        chk("t5_after_reset", 32'(first), 32'd6);
        idle(15);

        // 6: down held 50 cycles
        cnt = 0; first = -1;
        for (int k = 0; k < 50; k++) begin
            step(1'b0, 3'b100);
            if (down_pulse) begin cnt++; if (first < 0) first = k; end
        end
        chk("t6_first", 32'(first), 32'd6);
`ifdef BUTTON_AUTOREPEAT_EN
        chk("t6_count", 32'(cnt), 32'd1 + 32'((49 - 6 - RD) / RR + 1));
`else
        chk("t6_count", 32'(cnt), 32'd1);
`endif
        idle(15);

        // Random button activity with glitches and occasional resets
        prs = 3'b000;
        for (int i = 0; i < 3; i++) rem[i] = 1;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < 3; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    prs[i] = !prs[i];
                    rem[i] = ($urandom_range(0, 9) < 3) ? int'($urandom_range(1, 3))
                                                        : int'($urandom_range(4, 30));
                end
            end
            drop = ($urandom_range(0, 399) == 0) ? 1 : 0;
            step(drop[0], prs);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
